// File: rtl/rf_write_sched.sv
// Single register-file write port shared by the WB stage and a small FIFO of
// long-latency results. WB normally wins, but a long wait forces a buffer drain.
module rf_write_sched #(
  parameter int DEPTH  = 2,
  parameter int STARVE = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wb_we,
  input  logic [4:0]  wb_wn,
  input  logic [31:0] wb_d,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wn,
  input  logic [31:0] lu_d,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_wn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_wd,
  output logic        hz_stall,
  output logic        wb_hold,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

  logic [4:0]    wn_mem [DEPTH];
  logic [31:0]   d_mem  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   pending;

  logic        wb_req, force_drain, buf_nonempty, push, pop, grant_wb;
  logic [4:0]  head_wn;
  logic [31:0] head_d;
  logic [31:0] pending_next;

  assign buf_nonempty = (count != '0);
  assign wb_req       = wb_we & (wb_wn != 5'd0);
  assign lu_ready     = (count < DEPTH_C);
  assign force_drain  = buf_nonempty & (starve_cnt == STARVE_C);
  assign wb_hold      = force_drain & wb_req;
  assign head_wn      = wn_mem[rd_ptr];
  assign head_d       = d_mem[rd_ptr];

  // Head goes out when forced, or whenever WB has nothing to write.
  assign pop      = force_drain | (~wb_req & buf_nonempty);
  assign grant_wb = ~force_drain & wb_req;
  assign push     = lu_valid & lu_ready & (lu_wn != 5'd0);

  always_comb begin
    rf_we = 1'b0;
    rf_wn = 5'd0;
    rf_d  = 32'd0;
    if (pop) begin
      rf_we = 1'b1;
      rf_wn = head_wn;
      rf_d  = head_d;
    end else if (grant_wb) begin
      rf_we = 1'b1;
      rf_wn = wb_wn;
      rf_d  = wb_d;
    end
  end

  assign hz_stall = ((id_rs != 5'd0) & pending[id_rs]) |
                    ((id_rt != 5'd0) & pending[id_rt]) |
                    ((id_wd != 5'd0) & pending[id_wd]);

  // Clear first so that a same-cycle issue to the popped register stays pending.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head_wn] = 1'b0;
    if (issue_valid) pending_next[issue_wn] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wn_mem[wr_ptr] <= lu_wn;
      d_mem[wr_ptr]  <= lu_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pending    <= '0;
    end else begin
      pending <= pending_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop || !buf_nonempty)
        starve_cnt <= '0;
      else if (grant_wb && starve_cnt != STARVE_C)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
endmodule

// File: tb/tb_rf_write_sched.sv
// Directed, table-driven check of rf_write_sched: one vector per clock cycle,
// inputs applied after posedge and outputs compared at the following negedge.
module tb_rf_write_sched;
  logic        clk = 1'b0;
  logic        clrn;
  logic        wb_we, lu_valid, issue_valid;
  logic [4:0]  wb_wn, lu_wn, issue_wn, id_rs, id_rt, id_wd;
  logic [31:0] wb_d, lu_d;
  logic        lu_ready, hz_stall, wb_hold, rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;

  int vectors = 0;
  int miscompares = 0;

  rf_write_sched #(.DEPTH(2), .STARVE(3)) dut (
    .clk(clk), .clrn(clrn),
    .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
    .lu_valid(lu_valid), .lu_wn(lu_wn), .lu_d(lu_d), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_wn(issue_wn),
    .id_rs(id_rs), .id_rt(id_rt), .id_wd(id_wd),
    .hz_stall(hz_stall), .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;  logic [4:0] wb_wn;  logic [31:0] wb_d;
    logic        lu_v;   logic [4:0] lu_wn;  logic [31:0] lu_d;
    logic        iss_v;  logic [4:0] iss_wn;
    logic [4:0]  rs, rt, wd;
    logic        e_rdy, e_hz, e_hold, e_we;
    logic [4:0]  e_wn;   logic [31:0] e_d;
  } vec_t;

  function automatic vec_t mk(input logic a_we, input logic [4:0] a_wn, input logic [31:0] a_d,
                              input logic b_v, input logic [4:0] b_wn, input logic [31:0] b_d,
                              input logic i_v, input logic [4:0] i_wn,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wd,
                              input logic rdy, input logic hz, input logic hold,
                              input logic we, input logic [4:0] wn, input logic [31:0] d);
    vec_t v;
    v.wb_we = a_we; v.wb_wn = a_wn; v.wb_d = a_d;
    v.lu_v = b_v; v.lu_wn = b_wn; v.lu_d = b_d;
    v.iss_v = i_v; v.iss_wn = i_wn;
    v.rs = rs; v.rt = rt; v.wd = wd;
    v.e_rdy = rdy; v.e_hz = hz; v.e_hold = hold; v.e_we = we; v.e_wn = wn; v.e_d = d;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    wb_we = v.wb_we; wb_wn = v.wb_wn; wb_d = v.wb_d;
    lu_valid = v.lu_v; lu_wn = v.lu_wn; lu_d = v.lu_d;
    issue_valid = v.iss_v; issue_wn = v.iss_wn;
    id_rs = v.rs; id_rt = v.rt; id_wd = v.wd;
  endtask

  task automatic check(input string name, input vec_t v);
    vectors++;
    if (lu_ready !== v.e_rdy || hz_stall !== v.e_hz || wb_hold !== v.e_hold ||
        rf_we !== v.e_we || rf_wn !== v.e_wn || rf_d !== v.e_d) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b hz=%b hold=%b we=%b wn=%0d d=%h, want rdy=%b hz=%b hold=%b we=%b wn=%0d d=%h",
               name, lu_ready, hz_stall, wb_hold, rf_we, rf_wn, rf_d,
               v.e_rdy, v.e_hz, v.e_hold, v.e_we, v.e_wn, v.e_d);
    end else begin
      $display("ok   %s: rdy=%b hz=%b hold=%b we=%b wn=%0d d=%h",
               name, lu_ready, hz_stall, wb_hold, rf_we, rf_wn, rf_d);
    end
  endtask

  vec_t tbl [32];
  vec_t idle_v;

  initial begin
    // wb(we,wn,d) lu(v,wn,d) issue(v,wn) id(rs,rt,wd) | rdy hz hold we wn d
    tbl[0]  = mk(0,0,0,        0,0,0,         0,0, 0,0,0, 1,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,        0,0,0,         1,5, 0,0,0, 1,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,        1,5,'h55,      0,0, 5,0,0, 1,1,0,0,0,0);
    tbl[3]  = mk(0,0,0,        0,0,0,         0,0, 5,0,0, 1,1,0,1,5,'h55);
    tbl[4]  = mk(0,0,0,        0,0,0,         0,0, 5,0,0, 1,0,0,0,0,0);
    tbl[5]  = mk(0,0,0,        0,0,0,         1,8, 0,0,0, 1,0,0,0,0,0);
    tbl[6]  = mk(0,0,0,        0,0,0,         0,0, 8,0,0, 1,1,0,0,0,0);
    tbl[7]  = mk(1,0,'h1234,   0,0,0,         0,0, 0,0,0, 1,0,0,0,0,0);
    tbl[8]  = mk(0,0,0,        1,8,'h88,      0,0, 0,8,0, 1,1,0,0,0,0);
    tbl[9]  = mk(0,0,0,        0,0,0,         0,0, 0,0,8, 1,1,0,1,8,'h88);
    tbl[10] = mk(0,0,0,        0,0,0,         0,0, 8,0,0, 1,0,0,0,0,0);
    tbl[11] = mk(1,10,'hA0,    1,3,'h33,      1,3, 0,0,0, 1,0,0,1,10,'hA0);
    tbl[12] = mk(1,11,'hB1,    0,0,0,         0,0, 0,0,0, 1,0,0,1,11,'hB1);
    tbl[13] = mk(1,12,'hC1,    0,0,0,         0,0, 0,0,0, 1,0,0,1,12,'hC1);
    tbl[14] = mk(1,13,'hD1,    0,0,0,         0,0, 0,0,0, 1,0,0,1,13,'hD1);
    tbl[15] = mk(1,14,'hE1,    0,0,0,         0,0, 3,0,0, 1,1,1,1,3,'h33);
    tbl[16] = mk(1,14,'hE1,    0,0,0,         0,0, 3,0,0, 1,0,0,1,14,'hE1);
    tbl[17] = mk(1,1,1,        1,20,'h200,    0,0, 0,0,0, 1,0,0,1,1,1);
    tbl[18] = mk(1,2,2,        1,21,'h201,    0,0, 0,0,0, 1,0,0,1,2,2);
    tbl[19] = mk(1,3,3,        1,22,'h202,    0,0, 0,0,0, 0,0,0,1,3,3);
    tbl[20] = mk(1,4,4,        1,22,'h202,    0,0, 0,0,0, 0,0,0,1,4,4);
    tbl[21] = mk(1,5,5,        1,22,'h202,    0,0, 0,0,0, 0,0,1,1,20,'h200);
    tbl[22] = mk(1,5,5,        0,0,0,         0,0, 0,0,0, 1,0,0,1,5,5);
    tbl[23] = mk(0,0,0,        1,22,'h202,    0,0, 0,0,0, 1,0,0,1,21,'h201);
    tbl[24] = mk(0,0,0,        0,0,0,         0,0, 0,0,0, 1,0,0,1,22,'h202);
    tbl[25] = mk(0,0,0,        0,0,0,         0,0, 0,0,0, 1,0,0,0,0,0);
    tbl[26] = mk(0,0,0,        0,0,0,         1,7, 0,0,0, 1,0,0,0,0,0);
    tbl[27] = mk(0,0,0,        1,7,'h77,      0,0, 0,0,0, 1,0,0,0,0,0);
    tbl[28] = mk(0,0,0,        0,0,0,         1,7, 0,0,0, 1,0,0,1,7,'h77);
    tbl[29] = mk(0,0,0,        0,0,0,         0,0, 7,0,0, 1,1,0,0,0,0);
    tbl[30] = mk(0,0,0,        1,0,'hDEAD,    0,0, 0,0,0, 1,0,0,0,0,0);
    tbl[31] = mk(0,0,0,        0,0,0,         0,0, 0,0,0, 1,0,0,0,0,0);
    idle_v  = mk(0,0,0,        0,0,0,         0,0, 9,7,0, 1,0,0,0,0,0);

    clrn = 1'b0;
    apply(tbl[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", tbl[0]);
    clrn = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      apply(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i]);
    end

    // Fill the buffer with two entries and make pending non-zero, then reset mid-cycle.
    @(posedge clk); #1;
    apply(mk(1,1,1, 1,24,'h240, 1,9, 0,0,0, 1,0,0,1,1,1));
    @(negedge clk);
    check("rst_fill0", mk(1,1,1, 1,24,'h240, 1,9, 0,0,0, 1,0,0,1,1,1));
    @(posedge clk); #1;
    apply(mk(1,2,2, 1,25,'h250, 0,0, 0,0,0, 1,0,0,1,2,2));
    @(negedge clk);
    check("rst_fill1", mk(1,2,2, 1,25,'h250, 0,0, 0,0,0, 1,0,0,1,2,2));
    @(posedge clk); #1;
    apply(mk(0,0,0, 0,0,0, 0,0, 9,0,0, 0,1,0,1,24,'h240));
    @(negedge clk);
    check("rst_full", mk(0,0,0, 0,0,0, 0,0, 9,0,0, 0,1,0,1,24,'h240));
    apply(idle_v);
    #1 clrn = 1'b0;
    #1 check("rst_async", idle_v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      apply(idle_v);
      @(negedge clk);
      check($sformatf("post_rst%0d", i), idle_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
